mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Accepts one instruction per handshake from EXE. For loads/stores whose request EXE already issued (addr_ok seen), waits for the data-SRAM data_ok response, then aligns and extends load data.
- Forwards the result to WB, publishes a bypass/hazard view to ID, and discards responses that belong to flushed instructions.

Parameters:
- PASS_W, 128, width of opaque pass-through field (CSR/exception/rdcnt info) carried unchanged EXE→WB.
- DISCARD_W, 2, width of the outstanding-discard counter.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- exe_to_mem_valid  in  1  EXE holds a valid instruction ready to move.
- mem_allow  out  1  MEM can accept this cycle.
- exe_res_from_mem  in  1  instruction is a load.
- exe_gr_we  in  1  writes a GPR.
- exe_dest  in  5  destination register.
- exe_result  in  32  ALU/mul/rdcnt result; the load/store byte address for memory instructions.
- exe_pc  in  32  instruction PC.
- exe_ld_type  in  3  0=w,1=b,2=bu,3=h,4=hu.
- exe_req_issued  in  1  a data-SRAM request was accepted for this instruction.
- exe_pass  in  PASS_W  opaque field.
- data_sram_data_ok  in  1  response valid.
- data_sram_rdata  in  32  response word.
- wb_allow  in  1  WB can accept.
- wb_exception  in  1  flush: exception/ertn taken in WB.
- mem_to_wb_valid  out  1
- mem_gr_we  out  1
- mem_dest  out  5
- mem_final_result  out  32
- mem_pc  out  32
- mem_pass  out  PASS_W
- mem_dest_bus  out  5  dest for hazard check; 0 when invalid or no gr_we.
- mem_value_bus  out  32  bypass value.
- mem_load_pending  out  1  load in MEM whose data is not yet available.

Behaviour:
- Reset (resetn low, async): valid=0, all latched fields=0, data buffer empty, discard counter=0, wait flag=0. All outputs therefore 0, except mem_allow=1.
- Acceptance:
  - mem_allow = ~valid | (mem_go & wb_allow).
  - On exe_to_mem_valid & mem_allow & ~wb_exception: latch all exe_* fields, valid←1.
  - Else, if mem_go & wb_allow: valid←0.
  - wb_exception has priority: valid←0.
- Wait flag: set on acceptance with exe_req_issued=1; cleared when data arrives.
- Data buffer:
  - A data_ok with discard==0 while the wait flag is set captures rdata into the buffer (buf_valid←1).
  - Buffer is cleared when the instruction leaves or is flushed.
- mem_go = ~wait | buf_valid | (data_ok & discard==0).
- mem_to_wb_valid = valid & mem_go.
- Non-memory instructions: one cycle in MEM when wb_allow=1.
- Load result = buf_valid ? buffered word : data_sram_rdata, shifted right by 8*exe_result[1:0] and then extended:
  - b: sign-extend byte.
  - bu: zero-extend byte.
  - h: sign-extend half, shift by 8*{exe_result[1],0}.
  - hu: zero-extend half, same shift.
  - w: unshifted word.
- mem_final_result = res_from_mem ? load result : exe_result.
- Stores: data_ok completes them; no GPR write. Store data is discarded.
- Discard counter:
  - On wb_exception, increment by one for each of the following whose data_ok is not seen that cycle: (a) MEM holds a valid instruction with wait set and no buffer; (b) exe_to_mem_valid & exe_req_issued (request in flight, instruction dropped).
  - Each data_ok while discard>0 decrements the counter and is ignored.
  - Simultaneous increment and decrement net out.
  - Saturates at max; saturation is a design error, flagged by assertion.
- Hazard view:
  - mem_dest_bus = valid & gr_we ? dest : 0.
  - mem_load_pending = valid & res_from_mem & ~mem_go.

Optional Feature:
- MEM_LOAD_FWD_EN defined: mem_value_bus = mem_final_result, so a load's data is forwarded as soon as mem_go is high and ID stalls only while mem_load_pending.
- Undefined: mem_value_bus = exe_result. A new output-side rule applies: mem_load_pending = valid & res_from_mem, so ID must stall on any load in MEM until it leaves.

Decomposition:
- Shared package holds:
  - LD_W/LD_B/LD_BU/LD_H/LD_HU encodings.
  - DISCARD_W default.
  - The pass-field bit offsets used by WB.
- One sub-module, mem_load_align (combinational: word, addr[1:0], ld_type → 32-bit result), reused by later cache work.

Test Plan:
- add result 0x12345678, no req, wb_allow=1 → mem_to_wb_valid next cycle, final_result 0x12345678, MEM busy one cycle.
- ld.w addr 0x1000, data_ok 3 cycles after accept with rdata 0xDEADBEEF → mem_load_pending high 3 cycles, then final_result 0xDEADBEEF.
- ld.b addr 0x1003, rdata 0x80FF00FF → 0xFFFFFF80; ld.bu → 0x00000080; ld.hu addr 0x1002 → 0x000080FF.
- ld.h with data_ok while wb_allow=0 for 4 cycles, rdata 0x0000F00D → buffer holds value; on wb_allow, final_result 0xFFFFF00D; later rdata changes have no effect.
- ld.w waiting in MEM plus EXE issuing another load; wb_exception pulse → discard=2; next two data_ok ignored, mem_to_wb_valid stays 0; third load completes normally.
- resetn deasserted mid-wait → all outputs 0 immediately; after release, mem_allow=1 and discard=0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: load-type encodings,
// default sizes and the pass-field layout decoded by WB.
package mem_stage_pkg;

    localparam logic [2:0] LD_W  = 3'd0;
    localparam logic [2:0] LD_B  = 3'd1;
    localparam logic [2:0] LD_BU = 3'd2;
    localparam logic [2:0] LD_H  = 3'd3;
    localparam logic [2:0] LD_HU = 3'd4;

    localparam int DISCARD_W_DEF = 2;
    localparam int PASS_W_DEF    = 128;

    // Bit offsets inside the opaque pass field, consumed by WB
    localparam int PASS_CSR_NUM_LSB   = 0;
    localparam int PASS_CSR_WE_BIT    = 14;
    localparam int PASS_CSR_WDATA_LSB = 15;
    localparam int PASS_CSR_WMASK_LSB = 47;
    localparam int PASS_EXC_LSB       = 79;
    localparam int PASS_RDCNT_LSB     = 96;

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: selects byte/half from the response word
// and sign- or zero-extends it according to the load type.
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  logic [2:0]  ld_type,
    output logic [31:0] result
);

    logic [31:0] byte_sh;
    logic [15:0] half;

    assign byte_sh = word >> {addr, 3'b000};
    assign half    = addr[1] ? word[31:16] : word[15:0];

    always_comb begin
        result = word;
        unique case (1'b1)
            ld_type == LD_B:  result = {{24{byte_sh[7]}}, byte_sh[7:0]};
            ld_type == LD_BU: result = {24'h0, byte_sh[7:0]};
            ld_type == LD_H:  result = {{16{half[15]}}, half};
            ld_type == LD_HU: result = {16'h0, half};
            default:          result = word;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: waits for data-SRAM responses, aligns loads, drops
// responses of flushed requests. MEM_LOAD_FWD_EN enables load-data bypass.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int PASS_W    = PASS_W_DEF,
    parameter int DISCARD_W = DISCARD_W_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              exe_to_mem_valid,
    output logic              mem_allow,
    input  logic              exe_res_from_mem,
    input  logic              exe_gr_we,
    input  logic [4:0]        exe_dest,
    input  logic [31:0]       exe_result,
    input  logic [31:0]       exe_pc,
    input  logic [2:0]        exe_ld_type,
    input  logic              exe_req_issued,
    input  logic [PASS_W-1:0] exe_pass,
    input  logic              data_sram_data_ok,
    input  logic [31:0]       data_sram_rdata,
    input  logic              wb_allow,
    input  logic              wb_exception,
    output logic              mem_to_wb_valid,
    output logic              mem_gr_we,
    output logic [4:0]        mem_dest,
    output logic [31:0]       mem_final_result,
    output logic [31:0]       mem_pc,
    output logic [PASS_W-1:0] mem_pass,
    output logic [4:0]        mem_dest_bus,
    output logic [31:0]       mem_value_bus,
    output logic              mem_load_pending
);

    localparam int SUM_W = DISCARD_W + 2;
    localparam logic [SUM_W-1:0] DISC_MAX = SUM_W'((1 << DISCARD_W) - 1);

    logic              valid, gr_we, res_from_mem, wait_q, buf_valid;
    logic [4:0]        dest;
    logic [31:0]       result, pc, buf_data;
    logic [2:0]        ld_type;
    logic [PASS_W-1:0] pass;
    logic [DISCARD_W-1:0] discard;

    logic             data_ok_live, mem_go, accept, leave;
    logic             inc_a, inc_b, dec;
    logic [SUM_W-1:0] disc_sum;
    logic [31:0]      ld_word, ld_result;

    assign data_ok_live = data_sram_data_ok & (discard == '0);
    assign mem_go       = ~wait_q | buf_valid | data_ok_live;
    assign mem_allow    = ~valid | (mem_go & wb_allow);
    assign accept       = exe_to_mem_valid & mem_allow & ~wb_exception;
    assign leave        = valid & mem_go & wb_allow;

    // A live response belongs to MEM if it waits, else to the EXE request
    assign inc_a = wb_exception & valid & wait_q & ~buf_valid
                 & ~data_ok_live;
    assign inc_b = wb_exception & exe_to_mem_valid & exe_req_issued
                 & ~(data_ok_live & ~(valid & wait_q));
    assign dec   = data_sram_data_ok & (discard != '0);

    assign disc_sum = SUM_W'(discard) + SUM_W'(inc_a)
                    + SUM_W'(inc_b) - SUM_W'(dec);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid        <= 1'b0;
            gr_we        <= 1'b0;
            res_from_mem <= 1'b0;
            dest         <= '0;
            result       <= '0;
            pc           <= '0;
            ld_type      <= '0;
            pass         <= '0;
            wait_q       <= 1'b0;
            buf_valid    <= 1'b0;
            buf_data     <= '0;
            discard      <= '0;
        end else begin
            if (wb_exception)
                valid <= 1'b0;
            else if (accept)
                valid <= 1'b1;
            else if (leave)
                valid <= 1'b0;

            if (accept) begin
                gr_we        <= exe_gr_we;
                res_from_mem <= exe_res_from_mem;
                dest         <= exe_dest;
                result       <= exe_result;
                pc           <= exe_pc;
                ld_type      <= exe_ld_type;
                pass         <= exe_pass;
            end

            if (wb_exception)
                wait_q <= 1'b0;
            else if (accept)
                wait_q <= exe_req_issued;
            else if (data_ok_live)
                wait_q <= 1'b0;

            if (wb_exception | leave) begin
                buf_valid <= 1'b0;
            end else if (valid & wait_q & data_ok_live) begin
                buf_valid <= 1'b1;
                buf_data  <= data_sram_rdata;
            end

            discard <= (disc_sum > DISC_MAX) ? DISC_MAX[DISCARD_W-1:0]
                                             : disc_sum[DISCARD_W-1:0];
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (resetn)
            assert (disc_sum <= DISC_MAX);
    end
`endif

    assign ld_word = buf_valid ? buf_data : data_sram_rdata;

    mem_load_align u_align (
        .word    (ld_word),
        .addr    (result[1:0]),
        .ld_type (ld_type),
        .result  (ld_result)
    );

    assign mem_to_wb_valid  = valid & mem_go;
    assign mem_gr_we        = gr_we;
    assign mem_dest         = dest;
    assign mem_final_result = res_from_mem ? ld_result : result;
    assign mem_pc           = pc;
    assign mem_pass         = pass;
    assign mem_dest_bus     = (valid & gr_we) ? dest : 5'd0;

`ifdef MEM_LOAD_FWD_EN
    assign mem_value_bus    = mem_final_result;
    assign mem_load_pending = valid & res_from_mem & ~mem_go;
`else
    assign mem_value_bus    = result;
    assign mem_load_pending = valid & res_from_mem;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus random traffic checked
// against a transaction-level model with a queue of dropped responses.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int PW = 128;

    typedef struct packed {
        logic          res;
        logic          gr_we;
        logic [4:0]    dest;
        logic [31:0]   result;
        logic [31:0]   pc;
        logic [2:0]    t;
        logic          req;
        logic [PW-1:0] pass;
    } ins_t;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          exe_to_mem_valid = 1'b0;
    logic          mem_allow;
    logic          data_sram_data_ok = 1'b0;
    logic [31:0]   data_sram_rdata = '0;
    logic          wb_allow = 1'b1;
    logic          wb_exception = 1'b0;
    logic          mem_to_wb_valid, mem_gr_we, mem_load_pending;
    logic [4:0]    mem_dest, mem_dest_bus;
    logic [31:0]   mem_final_result, mem_pc, mem_value_bus;
    logic [PW-1:0] mem_pass;
    ins_t          ex = '0;

    always #5 clk = ~clk;

    mem_stage #(.PASS_W(PW), .DISCARD_W(2)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .exe_to_mem_valid  (exe_to_mem_valid),
        .mem_allow         (mem_allow),
        .exe_res_from_mem  (ex.res),
        .exe_gr_we         (ex.gr_we),
        .exe_dest          (ex.dest),
        .exe_result        (ex.result),
        .exe_pc            (ex.pc),
        .exe_ld_type       (ex.t),
        .exe_req_issued    (ex.req),
        .exe_pass          (ex.pass),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .wb_allow          (wb_allow),
        .wb_exception      (wb_exception),
        .mem_to_wb_valid   (mem_to_wb_valid),
        .mem_gr_we         (mem_gr_we),
        .mem_dest          (mem_dest),
        .mem_final_result  (mem_final_result),
        .mem_pc            (mem_pc),
        .mem_pass          (mem_pass),
        .mem_dest_bus      (mem_dest_bus),
        .mem_value_bus     (mem_value_bus),
        .mem_load_pending  (mem_load_pending)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model: instruction held in MEM plus a queue of responses to drop
    ins_t        m_ins = '0;
    bit          m_valid = 0;
    bit          m_have = 0;
    logic [31:0] m_data = '0;
    bit          q[$];
    bit          m_acc = 0;

    function automatic logic [31:0] ref_load(input logic [31:0] w,
                                             input logic [31:0] a,
                                             input logic [2:0] t);
        longint unsigned wv, b, h;
        wv = w;
        b  = (wv >> (8 * a[1:0])) % 256;
        h  = (wv >> (16 * a[1])) % 65536;
        case (t)
            LD_B:    return (b >= 128) ? 32'(b) - 32'd256 : 32'(b);
            LD_BU:   return 32'(b);
            LD_H:    return (h >= 32768) ? 32'(h) - 32'd65536 : 32'(h);
            LD_HU:   return 32'(h);
            default: return w;
        endcase
    endfunction

    function automatic bit m_wait();
        return m_valid && m_ins.req && !m_have;
    endfunction

    function automatic bit m_ready();
        bit live;
        live = data_sram_data_ok && q.size() == 0;
        return m_valid && (!m_wait() || live);
    endfunction

    task automatic model_reset();
        m_ins = '0;
        m_valid = 0;
        m_have = 0;
        m_data = '0;
        q.delete();
    endtask

    task automatic compare();
        bit rdy, pend;
        logic [31:0] word, fin, vb;
        rdy  = m_ready();
        word = m_have ? m_data : data_sram_rdata;
        fin  = m_ins.res ? ref_load(word, m_ins.result, m_ins.t)
                         : m_ins.result;
`ifdef MEM_LOAD_FWD_EN
        pend = m_valid && m_ins.res && !rdy;
        vb   = fin;
`else
        pend = m_valid && m_ins.res;
        vb   = m_ins.result;
`endif
        chk("allow", mem_allow, !m_valid || (rdy && wb_allow));
        chk("to_wb", mem_to_wb_valid, rdy);
        if (rdy) begin
            chk("final", mem_final_result, fin);
            chk("gr_we", mem_gr_we, m_ins.gr_we);
            chk("dest", mem_dest, m_ins.dest);
            chk("pc", mem_pc, m_ins.pc);
            chk("pass", mem_pass, m_ins.pass);
        end
        chk("dest_bus", mem_dest_bus,
            (m_valid && m_ins.gr_we) ? m_ins.dest : 5'd0);
        chk("pending", mem_load_pending, pend);
        chk("value_bus", mem_value_bus, vb);
    endtask

    task automatic step();
        bit rdy, allow, deliver;
        rdy     = m_ready();
        allow   = !m_valid || (rdy && wb_allow);
        deliver = data_sram_data_ok && q.size() == 0 && m_wait();
        m_acc   = 0;
        if (data_sram_data_ok && q.size() > 0)
            void'(q.pop_front());
        if (wb_exception) begin
            if (m_wait() && !deliver)
                q.push_back(1'b1);
            if (exe_to_mem_valid && ex.req)
                q.push_back(1'b1);
        end
        if (wb_exception) begin
            m_valid = 0;
            m_have  = 0;
        end else if (exe_to_mem_valid && allow) begin
            m_ins   = ex;
            m_valid = 1;
            m_have  = 0;
            m_acc   = 1;
        end else if (rdy && wb_allow) begin
            m_valid = 0;
            m_have  = 0;
        end else if (deliver) begin
            m_have = 1;
            m_data = data_sram_rdata;
        end
    endtask

    task automatic cycle();
        #4;
        compare();
        if (resetn)
            step();
        else
            model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        exe_to_mem_valid  = 1'b0;
        data_sram_data_ok = 1'b0;
        wb_exception      = 1'b0;
        wb_allow          = 1'b1;
        data_sram_rdata   = $urandom;
    endtask

    task automatic set_ex(input logic res, input logic we,
                          input logic [31:0] r, input logic [2:0] t,
                          input logic req);
        ex.res    = res;
        ex.gr_we  = we;
        ex.dest   = 5'($urandom_range(1, 31));
        ex.result = r;
        ex.pc     = $urandom;
        ex.t      = t;
        ex.req    = req;
        ex.pass   = {$urandom, $urandom, $urandom, $urandom};
        exe_to_mem_valid = 1'b1;
    endtask

    task automatic gen_ex();
        int k;
        k = $urandom_range(0, 2);
        set_ex(k == 1, k == 0 ? 1'($urandom) : (k == 1),
               $urandom, 3'($urandom_range(0, 4)), k != 0);
    endtask

    // Accept a load, answer it next cycle, check the aligned value
    task automatic do_load(input string tag, input logic [2:0] t,
                           input logic [31:0] a, input logic [31:0] rd,
                           input logic [31:0] exp);
        idle();
        set_ex(1'b1, 1'b1, a, t, 1'b1);
        cycle();
        idle();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = rd;
        #1;
        chk({tag, "_v"}, mem_to_wb_valid, 1'b1);
        chk(tag, mem_final_result, exp);
        cycle();
        idle();
    endtask

    bit hold;

    initial begin
        idle();
        #2;
        chk("rst_allow", mem_allow, 1'b1);
        chk("rst_to_wb", mem_to_wb_valid, 1'b0);
        cycle();
        resetn = 1'b1;
        cycle();

        set_ex(1'b0, 1'b1, 32'h1234_5678, LD_W, 1'b0);
        cycle();
        idle();
        #1;
        chk("add_v", mem_to_wb_valid, 1'b1);
        chk("add_r", mem_final_result, 32'h1234_5678);
        cycle();

        set_ex(1'b1, 1'b1, 32'h0000_1000, LD_W, 1'b1);
        cycle();
        idle();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("ldw_pend", mem_load_pending, 1'b1);
            chk("ldw_wait", mem_to_wb_valid, 1'b0);
            cycle();
        end
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hDEAD_BEEF;
        #1;
        chk("ldw_r", mem_final_result, 32'hDEAD_BEEF);
        cycle();
        idle();

        do_load("ldb", LD_B, 32'h1003, 32'h80FF_00FF, 32'hFFFF_FF80);
        do_load("ldbu", LD_BU, 32'h1003, 32'h80FF_00FF, 32'h0000_0080);
        do_load("ldhu", LD_HU, 32'h1002, 32'h80FF_00FF, 32'h0000_80FF);

        set_ex(1'b1, 1'b1, 32'h1000, LD_H, 1'b1);
        cycle();
        idle();
        wb_allow          = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0000_F00D;
        cycle();
        for (int i = 0; i < 3; i++) begin
            idle();
            wb_allow = 1'b0;
            cycle();
        end
        idle();
        data_sram_rdata = 32'h1234_5678;
        #1;
        chk("ldh_buf", mem_final_result, 32'hFFFF_F00D);
        chk("ldh_v", mem_to_wb_valid, 1'b1);
        cycle();

        set_ex(1'b1, 1'b1, 32'h2000, LD_W, 1'b1);
        cycle();
        set_ex(1'b1, 1'b1, 32'h2004, LD_W, 1'b1);
        wb_exception = 1'b1;
        cycle();
        idle();
        set_ex(1'b1, 1'b1, 32'h3000, LD_W, 1'b1);
        data_sram_data_ok = 1'b1;
        cycle();
        idle();
        data_sram_data_ok = 1'b1;
        #1;
        chk("disc_drop", mem_to_wb_valid, 1'b0);
        cycle();
        idle();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hCAFE_F00D;
        #1;
        chk("disc_v", mem_to_wb_valid, 1'b1);
        chk("disc_r", mem_final_result, 32'hCAFE_F00D);
        cycle();
        idle();

        set_ex(1'b1, 1'b1, 32'h4000, LD_W, 1'b1);
        cycle();
        idle();
        cycle();
        resetn = 1'b0;
        model_reset();
        #1;
        chk("rstw_to_wb", mem_to_wb_valid, 1'b0);
        chk("rstw_allow", mem_allow, 1'b1);
        chk("rstw_final", mem_final_result, 32'h0);
        chk("rstw_pc", mem_pc, 32'h0);
        chk("rstw_dbus", mem_dest_bus, 5'h0);
        chk("rstw_pend", mem_load_pending, 1'b0);
        cycle();
        resetn = 1'b1;
        cycle();
        do_load("rst_ld", LD_W, 32'h5000, 32'hA5A5_0101, 32'hA5A5_0101);

        hold = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!hold && $urandom_range(0, 2) == 0) begin
                gen_ex();
                hold = 1;
            end
            exe_to_mem_valid  = hold;
            wb_allow          = $urandom_range(0, 3) != 0;
            data_sram_data_ok = (q.size() > 0 || m_wait())
                                && $urandom_range(0, 2) == 0;
            data_sram_rdata   = $urandom;
            wb_exception      = q.size() <= 1
                                && $urandom_range(0, 19) == 0;
            cycle();
            if (m_acc || wb_exception)
                hold = 0;
        end
        idle();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
